// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter:
// port ids, read-return tag layout and latency bounds.
package dmem_arb_pkg;

    localparam logic PORT_CPU    = 1'b0;
    localparam logic PORT_LOADER = 1'b1;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    typedef struct packed {
        logic is_read;
        logic port_id;
    } rd_tag_t;

    localparam int TAG_W = $bits(rd_tag_t);

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant generator, round-robin or fixed priority,
// keeping the last granted port as its only state.
module rr_arb2
    import dmem_arb_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_grant;
    logic cpu_wins;

    // On contention the CPU wins unless it was the last one served.
    assign cpu_wins = (FIXED_PRIO != 0) || (last_grant == PORT_LOADER);

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = cpu_wins ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= PORT_LOADER;
        end else if (|gnt) begin
            last_grant <= gnt[1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port DMEM between the CPU and the UART loader,
// steering read data back to the requester after the BRAM latency.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AWIDTH     = 14,
    parameter int DWIDTH     = 32,
    parameter int RD_LATENCY = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_valid,
    output logic                  p0_ready,
    input  logic                  p0_we,
    input  logic [AWIDTH-1:0]     p0_addr,
    input  logic [DWIDTH-1:0]     p0_wdata,
    input  logic [DWIDTH/8-1:0]   p0_wbe,
    output logic                  p0_rvalid,
    output logic [DWIDTH-1:0]     p0_rdata,
    input  logic                  p1_valid,
    output logic                  p1_ready,
    input  logic                  p1_we,
    input  logic [AWIDTH-1:0]     p1_addr,
    input  logic [DWIDTH-1:0]     p1_wdata,
    input  logic [DWIDTH/8-1:0]   p1_wbe,
    output logic                  p1_rvalid,
    output logic [DWIDTH-1:0]     p1_rdata,
    output logic                  mem_en,
    output logic [DWIDTH/8-1:0]   mem_we,
    output logic [AWIDTH-1:0]     mem_addr,
    output logic [DWIDTH-1:0]     mem_din,
    input  logic [DWIDTH-1:0]     mem_dout
);

    // Out-of-range latencies are clamped to what the tag pipe supports.
    localparam int LAT =
        (RD_LATENCY < RD_LAT_MIN) ? RD_LAT_MIN :
        (RD_LATENCY > RD_LAT_MAX) ? RD_LAT_MAX : RD_LATENCY;

    logic [1:0] req;
    logic [1:0] gnt;
    logic       sel_we;
    rd_tag_t    new_tag;
    rd_tag_t    tail;

    logic [TAG_W-1:0] tag_q [LAT];

    assign req = {p1_valid, p0_valid};

    rr_arb2 #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_arb (
        .clk(clk),
        .rst(rst),
        .req(req),
        .gnt(gnt)
    );

    assign p0_ready = gnt[0];
    assign p1_ready = gnt[1];

    always_comb begin
        mem_en   = |gnt;
        mem_we   = '0;
        mem_addr = '0;
        mem_din  = '0;
        sel_we   = 1'b0;
        unique case (1'b1)
            gnt[0]: begin
                sel_we   = p0_we;
                mem_we   = p0_we ? p0_wbe : '0;
                mem_addr = p0_addr;
                mem_din  = p0_wdata;
            end
            gnt[1]: begin
                sel_we   = p1_we;
                mem_we   = p1_we ? p1_wbe : '0;
                mem_addr = p1_addr;
                mem_din  = p1_wdata;
            end
            default: ;
        endcase
    end

    assign new_tag.is_read = mem_en && !sel_we;
    assign new_tag.port_id = gnt[1];

    // One tag per cycle, bubbles included, so the tail lines up with mem_dout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= new_tag;
            for (int i = 1; i < LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tail = rd_tag_t'(tag_q[LAT-1]);

    assign p0_rvalid = tail.is_read && (tail.port_id == PORT_CPU);
    assign p1_rvalid = tail.is_read && (tail.port_id == PORT_LOADER);
    assign p0_rdata  = p0_rvalid ? mem_dout : '0;
    assign p1_rdata  = p1_rvalid ? mem_dout : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: five instances (RR at latency 1..4, fixed
// priority at latency 1) checked against a transaction-level model.
module tb_dmem_arbiter;

    localparam int N = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        p0_valid [N];
    logic        p0_ready [N];
    logic        p0_we    [N];
    logic [13:0] p0_addr  [N];
    logic [31:0] p0_wdata [N];
    logic [3:0]  p0_wbe   [N];
    logic        p0_rvalid[N];
    logic [31:0] p0_rdata [N];
    logic        p1_valid [N];
    logic        p1_ready [N];
    logic        p1_we    [N];
    logic [13:0] p1_addr  [N];
    logic [31:0] p1_wdata [N];
    logic [3:0]  p1_wbe   [N];
    logic        p1_rvalid[N];
    logic [31:0] p1_rdata [N];
    logic        mem_en   [N];
    logic [3:0]  mem_we   [N];
    logic [13:0] mem_addr [N];
    logic [31:0] mem_din  [N];
    logic [31:0] mem_dout [N];

    function automatic logic [31:0] preload(int a);
        case (a)
            1:       return 32'h1111_1111;
            2:       return 32'h2222_2222;
            16:      return 32'hDEAD_BEEF;
            32:      return 32'hAAAA_AAAA;
            16383:   return 32'h5A5A_5A5A;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int lat_of(int d);
        return (d == 4) ? 1 : d + 1;
    endfunction

    function automatic bit fix_of(int d);
        return d == 4;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int L = (g == 4) ? 1 : g + 1;
        localparam int F = (g == 4) ? 1 : 0;
        logic [31:0] bmem [16384];
        logic [31:0] dq [4];

        dmem_arbiter #(
            .AWIDTH(14), .DWIDTH(32), .RD_LATENCY(L), .FIXED_PRIO(F)
        ) u_dut (
            .clk(clk), .rst(rst),
            .p0_valid(p0_valid[g]), .p0_ready(p0_ready[g]),
            .p0_we(p0_we[g]), .p0_addr(p0_addr[g]),
            .p0_wdata(p0_wdata[g]), .p0_wbe(p0_wbe[g]),
            .p0_rvalid(p0_rvalid[g]), .p0_rdata(p0_rdata[g]),
            .p1_valid(p1_valid[g]), .p1_ready(p1_ready[g]),
            .p1_we(p1_we[g]), .p1_addr(p1_addr[g]),
            .p1_wdata(p1_wdata[g]), .p1_wbe(p1_wbe[g]),
            .p1_rvalid(p1_rvalid[g]), .p1_rdata(p1_rdata[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]),
            .mem_addr(mem_addr[g]), .mem_din(mem_din[g]),
            .mem_dout(mem_dout[g])
        );

        // BRAM model: registered read, L-stage output delay.
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < 16384; i++) bmem[i] <= preload(i);
                for (int k = 0; k < 4; k++) dq[k] <= '0;
            end else begin
                dq[0] <= bmem[mem_addr[g]];
                for (int k = 1; k < 4; k++) dq[k] <= dq[k-1];
                if (mem_en[g]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (mem_we[g][b])
                            bmem[mem_addr[g]][8*b +: 8] <= mem_din[g][8*b +: 8];
                    end
                end
            end
        end

        assign mem_dout[g] = dq[L-1];
    end

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        int          port;
        logic [31:0] data;
    } resp_t;

    resp_t       q [N][$];
    int          lastw [N];
    int          gsel  [N];
    logic [31:0] wmem [int];
    int          cyc;
    int          n_chk;
    int          n_fail;

    function automatic logic [31:0] ref_rd(int d, int a);
        int key = d * 16384 + a;
        if (wmem.exists(key)) return wmem[key];
        return preload(a);
    endfunction

    function automatic void ref_wr(int d, int a, logic [31:0] wd, logic [3:0] be);
        logic [31:0] v = ref_rd(d, a);
        for (int b = 0; b < 4; b++) begin
            if (be[b]) v[8*b +: 8] = wd[8*b +: 8];
        end
        wmem[d * 16384 + a] = v;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < N; d++) begin
            lastw[d] = 1;
            gsel[d] = -1;
            q[d].delete();
        end
        wmem.delete();
    endfunction

    function automatic void chk(string name, int d, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cyc%0d: got %h, expected %h",
                     name, d, cyc, act, exp);
        end
    endfunction

    task automatic sample();
        @(negedge clk);
        for (int d = 0; d < N; d++) begin
            int g = -1;
            bit e0 = 0, e1 = 0;
            logic [31:0] d0 = '0, d1 = '0;
            bit w;
            logic [13:0] a;
            logic [31:0] wd;
            logic [3:0] be;
            if (p0_valid[d] && p1_valid[d]) g = fix_of(d) ? 0 : 1 - lastw[d];
            else if (p0_valid[d]) g = 0;
            else if (p1_valid[d]) g = 1;
            w  = (g == 1) ? p1_we[d]    : p0_we[d];
            a  = (g == 1) ? p1_addr[d]  : p0_addr[d];
            wd = (g == 1) ? p1_wdata[d] : p0_wdata[d];
            be = (g == 1) ? p1_wbe[d]   : p0_wbe[d];
            chk("p0_ready", d, 32'(p0_ready[d]), 32'(g == 0));
            chk("p1_ready", d, 32'(p1_ready[d]), 32'(g == 1));
            chk("mem_en", d, 32'(mem_en[d]), 32'(g >= 0));
            chk("mem_we", d, 32'(mem_we[d]), (g >= 0 && w) ? 32'(be) : 32'h0);
            chk("mem_addr", d, 32'(mem_addr[d]), (g >= 0) ? 32'(a) : 32'h0);
            chk("mem_din", d, mem_din[d], (g >= 0) ? wd : 32'h0);
            if (q[d].size() > 0 && q[d][0].due == cyc) begin
                resp_t r = q[d].pop_front();
                if (r.port == 0) begin e0 = 1; d0 = r.data; end
                else begin e1 = 1; d1 = r.data; end
            end
            chk("p0_rvalid", d, 32'(p0_rvalid[d]), 32'(e0));
            chk("p1_rvalid", d, 32'(p1_rvalid[d]), 32'(e1));
            chk("p0_rdata", d, p0_rdata[d], d0);
            chk("p1_rdata", d, p1_rdata[d], d1);
            gsel[d] = g;
            if (g >= 0) begin
                lastw[d] = g;
                if (w) ref_wr(d, int'(a), wd, be);
                else q[d].push_back('{cyc + lat_of(d), g, ref_rd(d, int'(a))});
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic idle_all();
        for (int d = 0; d < N; d++) begin
            p0_valid[d] = 0; p0_we[d] = 0; p0_addr[d] = '0;
            p0_wdata[d] = '0; p0_wbe[d] = '0;
            p1_valid[d] = 0; p1_we[d] = 0; p1_addr[d] = '0;
            p1_wdata[d] = '0; p1_wbe[d] = '0;
        end
    endtask

    task automatic set_p(int d, int p, bit v, bit w, logic [13:0] a,
                         logic [31:0] wd, logic [3:0] be);
        if (p == 0) begin
            p0_valid[d] = v; p0_we[d] = w; p0_addr[d] = a;
            p0_wdata[d] = wd; p0_wbe[d] = be;
        end else begin
            p1_valid[d] = v; p1_we[d] = w; p1_addr[d] = a;
            p1_wdata[d] = wd; p1_wbe[d] = be;
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        int          d;
        bit          v0, w0;
        logic [13:0] a0;
        logic [31:0] wd0;
        logic [3:0]  be0;
        bit          v1, w1;
        logic [13:0] a1;
        logic [31:0] wd1;
        logic [3:0]  be1;
        bit          r0, r1;
    } vec_t;

    vec_t tbl [$];

    function automatic void add(int d,
        bit v0, bit w0, logic [13:0] a0, logic [31:0] wd0, logic [3:0] be0,
        bit v1, bit w1, logic [13:0] a1, logic [31:0] wd1, logic [3:0] be1,
        bit r0, bit r1);
        tbl.push_back('{d, v0, w0, a0, wd0, be0, v1, w1, a1, wd1, be1, r0, r1});
    endfunction

    initial begin
        n_chk = 0;
        n_fail = 0;
        cyc = 0;
        idle_all();
        model_reset();

        // Instance 0 (RR, lat 1): single read, contention, write/read, top address.
        add(0, 1,0,14'h0010,0,0,          0,0,0,0,0,                      1,0);
        add(0, 0,0,0,0,0,                 0,0,0,0,0,                      0,0);
        add(0, 1,0,14'h0001,0,0,          1,0,14'h0002,0,0,               0,1);
        add(0, 1,0,14'h0001,0,0,          1,0,14'h0002,0,0,               1,0);
        add(0, 1,0,14'h0001,0,0,          1,0,14'h0002,0,0,               0,1);
        add(0, 1,0,14'h0001,0,0,          1,0,14'h0002,0,0,               1,0);
        add(0, 0,0,0,0,0,                 1,1,14'h0020,32'h12345678,4'b0011, 0,1);
        add(0, 1,0,14'h0020,0,0,          0,0,0,0,0,                      1,0);
        add(0, 1,0,14'h0010,0,0,          1,0,14'h3FFF,0,0,               0,1);
        add(0, 1,0,14'h0010,0,0,          0,0,0,0,0,                      1,0);
        add(0, 0,0,0,0,0,                 0,0,0,0,0,                      0,0);
        // Instance 4 (fixed priority): port 1 starves until port 0 drops.
        for (int i = 0; i < 5; i++)
            add(4, 1,0,14'h0001,0,0,      1,0,14'h0002,0,0,               1,0);
        add(4, 0,0,0,0,0,                 1,0,14'h0002,0,0,               0,1);
        add(4, 0,0,0,0,0,                 0,0,0,0,0,                      0,0);
        add(4, 0,0,0,0,0,                 0,0,0,0,0,                      0,0);

        repeat (2) @(posedge clk);
        #1 rst = 0;
        cyc = 0;

        // Reset state: idle, nothing pending.
        step();

        foreach (tbl[i]) begin
            vec_t t = tbl[i];
            idle_all();
            set_p(t.d, 0, t.v0, t.w0, t.a0, t.wd0, t.be0);
            set_p(t.d, 1, t.v1, t.w1, t.a1, t.wd1, t.be1);
            sample();
            chk("tbl_ready0", t.d, 32'(p0_ready[t.d]), 32'(t.r0));
            chk("tbl_ready1", t.d, 32'(p1_ready[t.d]), 32'(t.r1));
            advance();
        end
        idle_all();

        // Latency sweep: 8 back-to-back reads on each RR instance.
        for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < 8; k++) begin
                logic [13:0] a;
                case (k % 4)
                    0: a = 14'h0001;
                    1: a = 14'h0002;
                    2: a = 14'h0010;
                    default: a = 14'h3FFF;
                endcase
                set_p(d, k % 2, 1, 0, a, 0, 0);
                set_p(d, 1 - (k % 2), 0, 0, 0, 0, 0);
                step();
            end
            idle_all();
            repeat (5) step();
        end

        // Reset mid-flight on the latency-3 instance.
        set_p(2, 0, 1, 0, 14'h0010, 0, 0);
        step();
        set_p(2, 0, 0, 0, 0, 0, 0);
        set_p(2, 1, 1, 0, 14'h0001, 0, 0);
        step();
        idle_all();
        #2 rst = 1;
        #1;
        for (int d = 0; d < N; d++) begin
            n_chk++;
            if (p0_rvalid[d] !== 1'b0 || p1_rvalid[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_rvalid inst%0d: got %b%b, expected 00",
                         d, p1_rvalid[d], p0_rvalid[d]);
            end
        end
        @(posedge clk);
        #1 rst = 0;
        model_reset();
        cyc++;
        repeat (5) step();
        set_p(2, 0, 1, 0, 14'h0001, 0, 0);
        set_p(2, 1, 1, 0, 14'h0002, 0, 0);
        sample();
        chk("rst_first_grant", 2, 32'(p0_ready[2]), 32'h1);
        advance();
        idle_all();
        repeat (5) step();

        // Random traffic on every instance, requests held until accepted.
        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < N; d++) begin
                for (int p = 0; p < 2; p++) begin
                    bit held = (p == 0) ? p0_valid[d] : p1_valid[d];
                    if (gsel[d] == p || !held) begin
                        logic [13:0] a;
                        case ($urandom_range(0, 4))
                            0: a = 14'h0001;
                            1: a = 14'h0002;
                            2: a = 14'h0010;
                            3: a = 14'h0020;
                            default: a = 14'h3FFF;
                        endcase
                        set_p(d, p, $urandom_range(0, 9) < 7,
                              $urandom_range(0, 3) == 0, a,
                              $urandom, 4'($urandom_range(0, 15)));
                    end
                end
                gsel[d] = -1;
            end
            step();
        end
        idle_all();
        repeat (6) step();

        for (int d = 0; d < N; d++)
            chk("drained", d, 32'(q[d].size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
